ulpi_reg_arbiter: RTL and testbench
===================================

// Module: ulpi_reg_arbiter
// PURPOSE
//  Owns the ULPI PHY register-access port of ulpi_wrapper (8-bit address/data, strobe/ack) in the 60MHz PHY domain.
//  After reset it runs a fixed boot sequence: read vendor ID, write Function Control, write OTG Control.
//  It then shares the port between two requesters (A, B) with round-robin arbitration and a per-access ack timeout.
// PARAMETERS
//  FUNC_CTRL_INIT  8'h45   value written to Function Control (addr 8'h04) during boot
//  OTG_CTRL_INIT   8'h00   value written to OTG Control (addr 8'h0A) during boot
//  TIMEOUT_CYCLES  255     max cycles stb_o waits for reg_ack_i before the access is abandoned (1..65535)
// PORTS
//  clk_i          in   1   PHY clock (60MHz)
//  rst_i          in   1   synchronous reset, active-high
//  reg_addr_o     out  8   ULPI register address to ulpi_wrapper
//  reg_stb_o      out  1   access strobe to ulpi_wrapper
//  reg_we_o       out  1   1=write, 0=read
//  reg_data_o     out  8   write data
//  reg_data_i     in   8   read data from ulpi_wrapper, valid with reg_ack_i
//  reg_ack_i      in   1   access complete
//  a_req_i/b_req_i        in   1  requester access request (held until own ack)
//  a_we_i/b_we_i          in   1  requester write enable
//  a_addr_i/b_addr_i      in   8  requester address
//  a_wdata_i/b_wdata_i    in   8  requester write data
//  a_ack_o/b_ack_o        out  1  one-cycle completion pulse
//  a_rdata_o/b_rdata_o    out  8  read data, valid with ack
//  a_err_o/b_err_o        out  1  completion was a timeout (valid with ack)
//  init_done_o    out  1   boot sequence finished (sticky until reset)
//  vid_o          out  16  vendor ID {reg 8'h01, reg 8'h00}
//  timeout_o      out  1   sticky: any access (boot or requester) timed out
// BEHAVIOUR
//  Reset: every output 0; state BOOT, boot step 0; round-robin pointer favours A; timeout counter 0.
//  Reset mid-access forces reg_stb_o low on the next edge; any ack_i received afterward is ignored.
//  Bus rule: reg_addr_o/we_o/data_o are registered and stay constant while reg_stb_o=1.
//   reg_stb_o rises 1 cycle after the access is launched and is held until reg_ack_i=1 or a timeout.
//   It is low in the cycle after the ack. reg_ack_i is ignored while reg_stb_o=0.
//  Timeout: a 16-bit counter clears when stb rises and increments every stb cycle.
//   When it reaches TIMEOUT_CYCLES without an ack, stb drops, timeout_o is set, and the access completes with rdata 8'h00 and err=1.
//  States: BOOT -> ISSUE -> WAIT -> (BOOT | RESP) ; ARB -> ISSUE -> WAIT -> RESP -> ARB.
//   BOOT steps: 0 = rd 8'h00 -> vid_o[7:0]; 1 = rd 8'h01 -> vid_o[15:8];
//    2 = wr 8'h04 FUNC_CTRL_INIT; 3 = wr 8'h0A OTG_CTRL_INIT.
//    After step 3 completes: init_done_o=1, go to ARB. A boot timeout still advances the step. The vid byte for a timed-out read is 8'h00.
//   ARB: requester req_i is ignored until init_done_o=1.
//    Only one request: it is granted. Both requests: grant the side the pointer favours, then point the pointer at the other side.
//    Grant latches we/addr/wdata; reg_stb_o rises the next cycle.
//   WAIT: ack in cycle N -> granted side ack_o=1 with rdata=reg_data_i (reads; 8'h00 for writes) and err=0 in cycle N+1 (RESP). The next arbitration follows in N+2.
//   A requester dropping req_i after grant does not cancel the access; its ack pulse is still issued.
//   Requests asserted during WAIT/RESP wait for ARB. Each requester gets at most one ack per grant.
//  Minimum back-to-back requester throughput: one access per (ack latency + 3) cycles.
// TESTING
//  1 Boot: PHY model acks each access after 3 cycles; reads return 8'h24 (addr 00) and 8'h04 (addr 01).
//    -> access order rd00, rd01, wr04=8'h45, wr0A=8'h00; vid_o=16'h0424; init_done_o=1; timeout_o=0.
//  2 a_req_i held high during boot -> no reg_stb_o for A before init_done_o; A served as first access after boot.
//  3 A and B both request (A rd 8'h16, B wr 8'h07=8'hAA) -> A first, then B; assert both again -> B first, then A.
//  4 PHY never acks B read -> stb high exactly TIMEOUT_CYCLES cycles; then b_ack_o=1, b_err_o=1, b_rdata_o=8'h00, timeout_o=1; A still serviced afterward.
//  5 rst_i pulsed while reg_stb_o=1 in WAIT -> stb low the next cycle; all outputs 0; boot restarts at rd 8'h00; late ack ignored.
//  6 A drops a_req_i one cycle after grant -> the access still completes; a_ack_o pulses exactly once; no second access issued.

Source files
------------

// File: rtl/ulpi_reg_arbiter_if.sv
// Register-access bundle around ulpi_reg_arbiter: the PHY-side strobe/ack port
// plus the two requester ports (A and B).
interface ulpi_reg_arbiter_if;
  logic [7:0] reg_addr_o;
  logic       reg_stb_o;
  logic       reg_we_o;
  logic [7:0] reg_data_o;
  logic [7:0] reg_data_i;
  logic       reg_ack_i;

  logic       a_req_i;
  logic       a_we_i;
  logic [7:0] a_addr_i;
  logic [7:0] a_wdata_i;
  logic       a_ack_o;
  logic [7:0] a_rdata_o;
  logic       a_err_o;

  logic       b_req_i;
  logic       b_we_i;
  logic [7:0] b_addr_i;
  logic [7:0] b_wdata_i;
  logic       b_ack_o;
  logic [7:0] b_rdata_o;
  logic       b_err_o;

  modport master (
    output reg_addr_o, reg_stb_o, reg_we_o, reg_data_o,
    input  reg_data_i, reg_ack_i,
    input  a_req_i, a_we_i, a_addr_i, a_wdata_i,
    output a_ack_o, a_rdata_o, a_err_o,
    input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
    output b_ack_o, b_rdata_o, b_err_o
  );

  modport slave (
    input  reg_addr_o, reg_stb_o, reg_we_o, reg_data_o,
    output reg_data_i, reg_ack_i,
    output a_req_i, a_we_i, a_addr_i, a_wdata_i,
    input  a_ack_o, a_rdata_o, a_err_o,
    output b_req_i, b_we_i, b_addr_i, b_wdata_i,
    input  b_ack_o, b_rdata_o, b_err_o
  );
endinterface

// File: rtl/ulpi_reg_arbiter.sv
// ULPI PHY register-port owner: boot sequence (vendor ID, Function/OTG Control),
// then round-robin sharing between requesters A and B with a per-access ack timeout.
//
// state | meaning
// BOOT  | load the bus fields for the current boot step
// ARB   | pick a requester (only after init_done_o)
// ISSUE | bus fields stable, raise strobe on the next edge
// WAIT  | strobe high, waiting for ack or timeout
// RESP  | one-cycle requester ack pulse
module ulpi_reg_arbiter #(
  parameter logic [7:0]  FUNC_CTRL_INIT = 8'h45,
  parameter logic [7:0]  OTG_CTRL_INIT  = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  ulpi_reg_arbiter_if.master        bus,
  output logic                      init_done_o,
  output logic [15:0]               vid_o,
  output logic                      timeout_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_BOOT, S_ARB, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_boot_step;
  logic        r_boot_acc;
  logic        r_own_b;
  logic        r_rr_b;
  logic [15:0] r_tmo_cnt;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;
  logic        r_we;
  logic        r_stb;
  logic        r_a_ack;
  logic [7:0]  r_a_rdata;
  logic        r_a_err;
  logic        r_b_ack;
  logic [7:0]  r_b_rdata;
  logic        r_b_err;
  logic        r_init_done;
  logic [15:0] r_vid;
  logic        r_timeout;

  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_ack;
  logic        w_tmo;
  logic        w_done;
  logic [7:0]  w_rdata;

  // Contention goes to the side the pointer favours; a lone request always wins.
  assign w_grant_a = r_init_done & bus.a_req_i & (~bus.b_req_i | ~r_rr_b);
  assign w_grant_b = r_init_done & bus.b_req_i & (~bus.a_req_i |  r_rr_b);
  assign w_ack     = r_stb & bus.reg_ack_i;
  assign w_tmo     = r_stb & ~bus.reg_ack_i & (r_tmo_cnt == TMO_LAST);
  assign w_done    = w_ack | w_tmo;
  assign w_rdata   = (w_ack && !r_we) ? bus.reg_data_i : 8'h00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_ISSUE;
      S_ARB:   if (w_grant_a || w_grant_b) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done) begin
          if (!r_boot_acc)             w_state_nxt = S_RESP;
          else if (r_boot_step == 2'd3) w_state_nxt = S_ARB;
          else                          w_state_nxt = S_BOOT;
        end
      end
      S_RESP:  w_state_nxt = S_ARB;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_boot_step <= 2'd0;
      r_boot_acc  <= 1'b0;
      r_own_b     <= 1'b0;
      r_rr_b      <= 1'b0;
      r_tmo_cnt   <= 16'd0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_we        <= 1'b0;
      r_stb       <= 1'b0;
      r_a_ack     <= 1'b0;
      r_a_rdata   <= 8'h00;
      r_a_err     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_b_rdata   <= 8'h00;
      r_b_err     <= 1'b0;
      r_init_done <= 1'b0;
      r_vid       <= 16'h0000;
      r_timeout   <= 1'b0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        S_BOOT: begin
          r_boot_acc <= 1'b1;
          case (r_boot_step)
            2'd0:    begin r_addr <= 8'h00; r_we <= 1'b0; r_wdata <= 8'h00;           end
            2'd1:    begin r_addr <= 8'h01; r_we <= 1'b0; r_wdata <= 8'h00;           end
            2'd2:    begin r_addr <= 8'h04; r_we <= 1'b1; r_wdata <= FUNC_CTRL_INIT;  end
            default: begin r_addr <= 8'h0A; r_we <= 1'b1; r_wdata <= OTG_CTRL_INIT;   end
          endcase
        end
        S_ARB: begin
          if (w_grant_a || w_grant_b) begin
            r_boot_acc <= 1'b0;
            r_own_b    <= w_grant_b;
            r_addr     <= w_grant_b ? bus.b_addr_i  : bus.a_addr_i;
            r_we       <= w_grant_b ? bus.b_we_i    : bus.a_we_i;
            r_wdata    <= w_grant_b ? bus.b_wdata_i : bus.a_wdata_i;
            if (bus.a_req_i && bus.b_req_i) r_rr_b <= w_grant_a;
          end
        end
        S_ISSUE: begin
          r_stb     <= 1'b1;
          r_tmo_cnt <= 16'd0;
        end
        S_WAIT: begin
          if (w_done) begin
            r_stb <= 1'b0;
            if (w_tmo) r_timeout <= 1'b1;
            if (r_boot_acc) begin
              if (r_boot_step == 2'd0) r_vid[7:0]  <= w_rdata;
              if (r_boot_step == 2'd1) r_vid[15:8] <= w_rdata;
              if (r_boot_step == 2'd3) r_init_done <= 1'b1;
              r_boot_step <= r_boot_step + 2'd1;
            end else if (r_own_b) begin
              r_b_ack   <= 1'b1;
              r_b_rdata <= w_rdata;
              r_b_err   <= w_tmo;
            end else begin
              r_a_ack   <= 1'b1;
              r_a_rdata <= w_rdata;
              r_a_err   <= w_tmo;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.reg_addr_o = r_addr;
  assign bus.reg_stb_o  = r_stb;
  assign bus.reg_we_o   = r_we;
  assign bus.reg_data_o = r_wdata;
  assign bus.a_ack_o    = r_a_ack;
  assign bus.a_rdata_o  = r_a_rdata;
  assign bus.a_err_o    = r_a_err;
  assign bus.b_ack_o    = r_b_ack;
  assign bus.b_rdata_o  = r_b_rdata;
  assign bus.b_err_o    = r_b_err;
  assign init_done_o    = r_init_done;
  assign vid_o          = r_vid;
  assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Bench for ulpi_reg_arbiter: behavioural PHY with register memory, directed
// scenarios plus randomized requester rounds against an order/data model.
module tb_ulpi_reg_arbiter;
  localparam int TMO     = 20;
  localparam int CYC_LIM = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done;
  logic [15:0] vid;
  logic        tmo;

  ulpi_reg_arbiter_if bif ();

  ulpi_reg_arbiter #(
    .FUNC_CTRL_INIT (8'h45),
    .OTG_CTRL_INIT  (8'h00),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bif),
    .init_done_o (init_done),
    .vid_o       (vid),
    .timeout_o   (tmo)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem [256];
  int          phy_lat = 3;
  bit          phy_noack = 1'b0;
  bit          force_ack = 1'b0;
  bit          ack_forced = 1'b0;
  int          cnt = 0;
  int          last_len = 0;
  logic [16:0] log_q [$];
  logic [16:0] cur_acc;
  bit          rr_b = 1'b0;
  bit          exp_tmo = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // read accesses carry no meaningful write data
  function automatic logic [16:0] acc_key(input logic [16:0] x);
    return x[16] ? x : {x[16:8], 8'h00};
  endfunction

  // PHY: acks after phy_lat strobe cycles, logs each access at strobe rise
  always @(negedge clk) begin
    if (rst) begin
      bif.reg_ack_i = 1'b0;
      cnt = 0;
      ack_forced = 1'b0;
    end else begin
      if (bif.reg_ack_i && !ack_forced) begin
        check("stb_low_after_ack", 32'(bif.reg_stb_o), 32'd0);
        last_len = cnt;
        cnt = 0;
      end
      bif.reg_ack_i = 1'b0;
      ack_forced = 1'b0;
      if (force_ack) begin
        bif.reg_ack_i = 1'b1;
        ack_forced = 1'b1;
        force_ack = 1'b0;
      end else if (bif.reg_stb_o) begin
        if (cnt == 0) begin
          cur_acc = {bif.reg_we_o, bif.reg_addr_o, bif.reg_data_o};
          log_q.push_back(cur_acc);
        end else begin
          check("bus_stable", 32'({bif.reg_we_o, bif.reg_addr_o, bif.reg_data_o}), 32'(cur_acc));
        end
        cnt++;
        if (!phy_noack && cnt == phy_lat) begin
          bif.reg_ack_i = 1'b1;
          if (bif.reg_we_o) begin
            mem[bif.reg_addr_o] = bif.reg_data_o;
            bif.reg_data_i = 8'($urandom);
          end else begin
            bif.reg_data_i = mem[bif.reg_addr_o];
          end
        end
      end else if (cnt != 0) begin
        last_len = cnt;
        cnt = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_bus", 32'({bif.reg_addr_o, bif.reg_stb_o, bif.reg_we_o, bif.reg_data_o}), 32'd0);
    check("rst_req", 32'({bif.a_ack_o, bif.a_rdata_o, bif.a_err_o, bif.b_ack_o, bif.b_rdata_o, bif.b_err_o}), 32'd0);
    check("rst_status", 32'({init_done, vid, tmo}), 32'd0);
    repeat (2) @(negedge clk);
    log_q.delete();
    rr_b = 1'b0;
    exp_tmo = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_boot();
    logic [16:0] exp_boot [4];
    int n = 0;
    exp_boot[0] = {1'b0, 8'h00, 8'h00};
    exp_boot[1] = {1'b0, 8'h01, 8'h00};
    exp_boot[2] = {1'b1, 8'h04, 8'h45};
    exp_boot[3] = {1'b1, 8'h0A, 8'h00};
    while (!init_done && n < CYC_LIM) begin
      @(negedge clk);
      n++;
    end
    check("boot_done", 32'(init_done), 32'd1);
    check("boot_log_count", 32'(log_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (log_q.size() > 0)
        check($sformatf("boot_acc%0d", i), 32'(acc_key(log_q.pop_front())), 32'(exp_boot[i]));
    end
    check("boot_vid", 32'(vid), 32'h0424);
    check("boot_timeout", 32'(tmo), 32'(exp_tmo));
  endtask

  task automatic run_round(input bit ra, input bit rb, input bit drop_a_early);
    bit          ord [2];
    int          n;
    int          got = 0;
    int          acks_a = 0;
    int          acks_b = 0;
    int          cyc = 0;
    logic [7:0]  exp_rd [2];
    logic [16:0] exp_acc [2];
    bit          side;

    if (ra && rb) begin
      ord[0] = rr_b;
      ord[1] = !rr_b;
      n = 2;
      rr_b = !rr_b;
    end else begin
      ord[0] = rb;
      ord[1] = 1'b0;
      n = 1;
    end
    exp_rd[0]  = (bif.a_we_i || phy_noack) ? 8'h00 : mem[bif.a_addr_i];
    exp_rd[1]  = (bif.b_we_i || phy_noack) ? 8'h00 : mem[bif.b_addr_i];
    exp_acc[0] = {bif.a_we_i, bif.a_addr_i, bif.a_wdata_i};
    exp_acc[1] = {bif.b_we_i, bif.b_addr_i, bif.b_wdata_i};
    if (phy_noack) exp_tmo = 1'b1;

    bif.a_req_i = ra;
    bif.b_req_i = rb;
    while (got < n && cyc < CYC_LIM) begin
      @(negedge clk);
      cyc++;
      if (drop_a_early && bif.a_req_i && log_q.size() > 0) bif.a_req_i = 1'b0;
      if (bif.a_ack_o) acks_a++;
      if (bif.b_ack_o) acks_b++;
      if (bif.a_ack_o || bif.b_ack_o) begin
        check("ack_side", 32'({bif.a_ack_o, bif.b_ack_o}), ord[got] ? 32'd1 : 32'd2);
        side = bif.b_ack_o;
        check(side ? "b_rdata" : "a_rdata", 32'(side ? bif.b_rdata_o : bif.a_rdata_o), 32'(exp_rd[side]));
        check(side ? "b_err" : "a_err", 32'(side ? bif.b_err_o : bif.a_err_o), 32'(phy_noack));
        if (side) bif.b_req_i = 1'b0;
        else      bif.a_req_i = 1'b0;
        got++;
      end
    end
    check("round_complete", 32'(got), 32'(n));
    bif.a_req_i = 1'b0;
    bif.b_req_i = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bif.a_ack_o) acks_a++;
      if (bif.b_ack_o) acks_b++;
    end
    check("a_ack_count", 32'(acks_a), 32'(ra));
    check("b_ack_count", 32'(acks_b), 32'(rb));
    check("access_count", 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (log_q.size() > 0)
        check($sformatf("access%0d", i), 32'(acc_key(log_q.pop_front())), 32'(acc_key(exp_acc[ord[i]])));
    end
    check("timeout_flag", 32'(tmo), 32'(exp_tmo));
  endtask

  task automatic set_a(input bit we, input logic [7:0] addr, input logic [7:0] wdata);
    bif.a_we_i = we; bif.a_addr_i = addr; bif.a_wdata_i = wdata;
  endtask

  task automatic set_b(input bit we, input logic [7:0] addr, input logic [7:0] wdata);
    bif.b_we_i = we; bif.b_addr_i = addr; bif.b_wdata_i = wdata;
  endtask

  initial begin
    int r;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h24;
    mem[1] = 8'h04;
    bif.reg_ack_i  = 1'b0;
    bif.reg_data_i = 8'h00;
    bif.a_req_i = 1'b0;
    bif.b_req_i = 1'b0;
    set_a(1'b0, 8'h00, 8'h00);
    set_b(1'b0, 8'h00, 8'h00);

    // plain boot
    do_reset();
    wait_boot();

    // A requesting throughout boot is served only afterwards
    set_a(1'b0, 8'h33, 8'h00);
    bif.a_req_i = 1'b1;
    do_reset();
    wait_boot();
    run_round(1'b1, 1'b0, 1'b0);

    // contention alternates
    set_a(1'b0, 8'h16, 8'h00);
    set_b(1'b1, 8'h07, 8'hAA);
    run_round(1'b1, 1'b1, 1'b0);
    run_round(1'b1, 1'b1, 1'b0);
    check("mem_07", 32'(mem[8'h07]), 32'hAA);

    // B read never acked
    phy_noack = 1'b1;
    set_b(1'b0, 8'h90, 8'h00);
    run_round(1'b0, 1'b1, 1'b0);
    check("stb_len_timeout", 32'(last_len), 32'(TMO));
    phy_noack = 1'b0;
    set_a(1'b0, 8'h21, 8'h00);
    run_round(1'b1, 1'b0, 1'b0);

    // A withdraws its request right after grant
    set_a(1'b1, 8'h44, 8'h5C);
    run_round(1'b1, 1'b0, 1'b1);

    // randomized rounds
    for (int k = 0; k < 20; k++) begin
      phy_lat = $urandom_range(1, 6);
      r = $urandom_range(1, 3);
      set_a(1'($urandom), 8'($urandom_range(8'h10, 8'h7F)), 8'($urandom));
      set_b(1'($urandom), 8'($urandom_range(8'h80, 8'hFF)), 8'($urandom));
      run_round(r[0], r[1], 1'b0);
    end

    // reset in the middle of a strobe, then a stray ack
    phy_lat = 10;
    set_a(1'b0, 8'h55, 8'h00);
    bif.a_req_i = 1'b1;
    n = 0;
    while (!bif.reg_stb_o && n < CYC_LIM) begin
      @(negedge clk);
      n++;
    end
    check("stb_before_reset", 32'(bif.reg_stb_o), 32'd1);
    @(negedge clk);
    bif.a_req_i = 1'b0;
    phy_lat = 3;
    do_reset();
    force_ack = 1'b1;
    wait_boot();
    run_round(1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
